// File: rtl/ready_bits_table.sv
// Ready-bits table: one INFO_WIDTH-bit register per wavefront slot.
// Each slot accepts an OR-in set, a bit-clear and a whole-slot flush. A
// registered read port and a sticky out-of-range address flag sit beside
// the table.
module ready_bits_table #(
  parameter int INFO_WIDTH  = 8,
  parameter int NUM_WF      = 40,
  parameter int WF_ID_WIDTH = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         set_en,
  input  logic [WF_ID_WIDTH-1:0]       set_wfid,
  input  logic [INFO_WIDTH-1:0]        set_bits,
  input  logic                         clr_en,
  input  logic [WF_ID_WIDTH-1:0]       clr_wfid,
  input  logic [INFO_WIDTH-1:0]        clr_bits,
  input  logic                         flush_en,
  input  logic [WF_ID_WIDTH-1:0]       flush_wfid,
  input  logic [WF_ID_WIDTH-1:0]       rd_wfid,
  output logic [INFO_WIDTH*NUM_WF-1:0] table_out,
  output logic [NUM_WF-1:0]            pending,
  output logic [INFO_WIDTH-1:0]        rd_bits,
  output logic                         addr_err
);

  // One extra bit so the comparison still works when NUM_WF == 2^WF_ID_WIDTH.
  localparam logic [WF_ID_WIDTH:0] NUM_WF_L = (WF_ID_WIDTH + 1)'(NUM_WF);

  logic [INFO_WIDTH-1:0] slots_q [NUM_WF];
  logic [INFO_WIDTH-1:0] slots_d [NUM_WF];
  logic [INFO_WIDTH-1:0] rd_bits_q, rd_bits_d;
  logic                  addr_err_q, addr_err_d;

  logic set_oor, clr_oor, flush_oor;

  assign set_oor   = ({1'b0, set_wfid}   >= NUM_WF_L);
  assign clr_oor   = ({1'b0, clr_wfid}   >= NUM_WF_L);
  assign flush_oor = ({1'b0, flush_wfid} >= NUM_WF_L);

  // Next-state for every slot, read port and error flag. An out-of-range id
  // matches no slot index, so it cannot modify the table.
  always_comb begin
    addr_err_d = addr_err_q | (set_en & set_oor) | (clr_en & clr_oor) |
                 (flush_en & flush_oor);
    rd_bits_d  = '0;
    for (int w = 0; w < NUM_WF; w++) begin
      slots_d[w] = slots_q[w];
      if (clr_en && clr_wfid == WF_ID_WIDTH'(w))
        slots_d[w] = slots_d[w] & ~clr_bits;
      // Set is applied after clear so a set wins on overlapping bits.
      if (set_en && set_wfid == WF_ID_WIDTH'(w))
        slots_d[w] = slots_d[w] | set_bits;
      // Flush overrides both set and clear to the same slot.
      if (flush_en && flush_wfid == WF_ID_WIDTH'(w))
        slots_d[w] = '0;
      // Read samples pre-update contents; no write bypass.
      if (rd_wfid == WF_ID_WIDTH'(w))
        rd_bits_d = slots_q[w];
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < NUM_WF; w++) slots_q[w] <= '0;
      rd_bits_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      for (int w = 0; w < NUM_WF; w++) slots_q[w] <= slots_d[w];
      rd_bits_q  <= rd_bits_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Outputs come straight from registers.
  for (genvar g = 0; g < NUM_WF; g++) begin : g_out
    assign table_out[INFO_WIDTH*g +: INFO_WIDTH] = slots_q[g];
    assign pending[g]                            = |slots_q[g];
  end

  assign rd_bits  = rd_bits_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_ready_bits_table.sv
// Testbench for ready_bits_table: directed scenarios plus random traffic
// compared each cycle against a slot-array reference model.
module tb_ready_bits_table;

  logic         clk = 1'b0;
  logic         rst;
  logic         set_en, clr_en, flush_en;
  logic [5:0]   set_wfid, clr_wfid, flush_wfid, rd_wfid;
  logic [7:0]   set_bits, clr_bits;
  logic [319:0] table_out;
  logic [39:0]  pending;
  logic [7:0]   rd_bits;
  logic         addr_err;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] m [40];
  logic [7:0] mrd;
  logic       merr;

  ready_bits_table dut (
    .clk(clk), .rst(rst),
    .set_en(set_en), .set_wfid(set_wfid), .set_bits(set_bits),
    .clr_en(clr_en), .clr_wfid(clr_wfid), .clr_bits(clr_bits),
    .flush_en(flush_en), .flush_wfid(flush_wfid),
    .rd_wfid(rd_wfid),
    .table_out(table_out), .pending(pending),
    .rd_bits(rd_bits), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int w = 0; w < 40; w++) m[w] = 8'h00;
    mrd  = 8'h00;
    merr = 1'b0;
  endtask

  task automatic idle_inputs();
    set_en = 0; clr_en = 0; flush_en = 0;
    set_wfid = 0; clr_wfid = 0; flush_wfid = 0;
    set_bits = 0; clr_bits = 0;
  endtask

  // Advance one clock; the model applies the slot rules to this cycle's inputs.
  task automatic tick();
    logic [7:0] nx [40];
    logic [7:0] nrd;
    logic       nerr;
    for (int w = 0; w < 40; w++) begin
      if (flush_en && flush_wfid == w) nx[w] = 8'h00;
      else begin
        nx[w] = m[w];
        if (clr_en && clr_wfid == w) nx[w] = nx[w] & ~clr_bits;
        if (set_en && set_wfid == w) nx[w] = nx[w] | set_bits;
      end
    end
    nrd  = (rd_wfid < 40) ? m[rd_wfid] : 8'h00;
    nerr = merr | (set_en && set_wfid >= 40) | (clr_en && clr_wfid >= 40) |
           (flush_en && flush_wfid >= 40);
    @(posedge clk);
    if (rst) begin
      m = nx; mrd = nrd; merr = nerr;
    end else begin
      model_clear();
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [319:0] et;
    logic [39:0]  ep;
    for (int w = 0; w < 40; w++) begin
      et[8*w +: 8] = m[w];
      ep[w]        = |m[w];
    end
    total++;
    assert (table_out === et) else begin
      bad++; $error("FAIL %s table_out got %h exp %h", tag, table_out, et);
    end
    total++;
    assert (pending === ep) else begin
      bad++; $error("FAIL %s pending got %h exp %h", tag, pending, ep);
    end
    total++;
    assert (rd_bits === mrd) else begin
      bad++; $error("FAIL %s rd_bits got %h exp %h", tag, rd_bits, mrd);
    end
    total++;
    assert (addr_err === merr) else begin
      bad++; $error("FAIL %s addr_err got %b exp %b", tag, addr_err, merr);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++; $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic check1(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++; $error("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] rand_id();
    if ($urandom_range(0, 19) == 0) return 6'($urandom_range(40, 63));
    return 6'($urandom_range(0, 39));
  endfunction

  initial begin
    rst = 1'b0;
    rd_wfid = 0;
    idle_inputs();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b1;

    // Slot 0 = 0x81 then slot 39 = 0x01
    set_en = 1; set_wfid = 0; set_bits = 8'h81; tick();
    set_wfid = 39; set_bits = 8'h01; tick();
    idle_inputs(); tick();
    check_all("corner_slots");
    check8("slot0", table_out[7:0], 8'h81);
    check8("slot39", table_out[319:312], 8'h01);
    total++;
    assert (pending === 40'h80_0000_0001) else begin
      bad++; $error("FAIL pending_corner got %h exp %h", pending, 40'h80_0000_0001);
    end

    // Set wins over clear on the same bit
    set_en = 1; set_wfid = 5; set_bits = 8'h0F; tick();
    set_bits = 8'h30; clr_en = 1; clr_wfid = 5; clr_bits = 8'h11; tick();
    idle_inputs();
    check_all("set_clr_same");
    check8("slot5", table_out[47:40], 8'h3E);

    // Flush overrides set and clear
    set_en = 1; set_wfid = 7; set_bits = 8'hFF; tick();
    flush_en = 1; flush_wfid = 7; set_bits = 8'h01;
    clr_en = 1; clr_wfid = 7; clr_bits = 8'h02; tick();
    idle_inputs();
    check_all("flush_wins");
    check8("slot7", table_out[63:56], 8'h00);
    check1("pending7", pending[7], 1'b0);

    // Registered read with no bypass
    set_en = 1; set_wfid = 3; set_bits = 8'hAA; tick();
    idle_inputs(); rd_wfid = 3; clr_en = 1; clr_wfid = 3; clr_bits = 8'hFF; tick();
    check8("rd_pre", rd_bits, 8'hAA);
    idle_inputs(); tick();
    check8("rd_post", rd_bits, 8'h00);
    check_all("rd_seq");
    rd_wfid = 50; tick();
    check8("rd_oor", rd_bits, 8'h00);
    check1("rd_oor_noerr", addr_err, 1'b0);

    // Out-of-range set: no slot changes, sticky error
    set_en = 1; set_wfid = 40; set_bits = 8'hFF; tick();
    idle_inputs();
    check_all("oor_set");
    check1("addr_err_set", addr_err, 1'b1);
    for (int i = 0; i < 100; i++) begin
      tick();
      check1("addr_err_hold", addr_err, 1'b1);
    end
    check_all("oor_idle");

    // Populate 10 slots, then asynchronous reset between edges
    for (int i = 0; i < 10; i++) begin
      set_en = 1; set_wfid = 6'(i * 4); set_bits = 8'(i + 1); tick();
    end
    idle_inputs(); rd_wfid = 4; tick();
    check_all("populated");
    #2;
    rst = 1'b0;
    model_clear();
    #1;
    check_all("async_reset");
    set_en = 1; set_wfid = 9; set_bits = 8'h5A;
    tick();
    check_all("write_in_reset");
    #1;
    rst = 1'b1;
    set_wfid = 12; set_bits = 8'hC3; tick();
    idle_inputs(); tick();
    check_all("after_release");
    check8("slot12", table_out[103:96], 8'hC3);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      set_en = 1'($urandom); set_wfid = rand_id(); set_bits = 8'($urandom);
      clr_en = 1'($urandom); clr_wfid = rand_id(); clr_bits = 8'($urandom);
      flush_en = ($urandom_range(0, 3) == 0); flush_wfid = rand_id();
      rd_wfid = rand_id();
      if ($urandom_range(0, 2) == 0) clr_wfid = set_wfid;
      if ($urandom_range(0, 4) == 0) flush_wfid = set_wfid;
      tick();
      check_all("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
